// File: rtl/march_scheduler.sv
// march_scheduler: per-pixel ray-march sequencer.
// It accepts a pixel job and issues one sdf evaluation per march step.
// After each result it decides whether the ray hit, escaped or ran out of
// steps, and holds the result until it is consumed.
//
// state | meaning
// IDLE  | ready for a new pixel job
// ISSUE | one-cycle start pulse to the sdf pipeline
// WAIT  | counting down the sdf pipeline latency
// EVAL  | sdf_distance valid this cycle; classify hit / far / limit / step
// DONE  | result presented, waiting for res_ready
module march_scheduler #(
  parameter int          SDF_LAT   = 12,
  parameter int          MAX_STEPS = 32,
  parameter logic [26:0] HIT_EPS   = 27'h1F00000,
  parameter logic [26:0] FAR_LIMIT = 27'h2240000,
  parameter int          CORDW     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [CORDW-1:0] job_px,
  input  logic [CORDW-1:0] job_py,
  output logic             sdf_issue,
  output logic [CORDW-1:0] sdf_px,
  output logic [CORDW-1:0] sdf_py,
  input  logic [26:0]      sdf_distance,
  output logic             march_advance,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CORDW-1:0] res_px,
  output logic [CORDW-1:0] res_py,
  output logic             res_hit,
  output logic [7:0]       res_steps
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DONE} state_t;

  localparam logic [5:0] LAT_LOAD    = 6'(SDF_LAT - 2);
  localparam logic [7:0] MAX_STEPS_W = 8'(MAX_STEPS);

  state_t           state_q;
  logic [5:0]       cnt_q;
  logic [7:0]       steps_q;
  logic [CORDW-1:0] px_q;
  logic [CORDW-1:0] py_q;
  logic             job_ready_q;
  logic             sdf_issue_q;
  logic             res_valid_q;
  logic             hit_q;

  logic [7:0]       step_n_d;
  logic             is_hit_d;
  logic             is_far_d;
  logic             at_limit_d;

  // Classify the distance arriving this cycle; only acted on in EVAL.
  // Sign bit alone marks a hit, whatever the magnitude.
  always_comb begin
    step_n_d   = steps_q + 8'd1;
    is_hit_d   = sdf_distance[26] || (sdf_distance[25:0] < HIT_EPS[25:0]);
    is_far_d   = (sdf_distance[25:0] >= FAR_LIMIT[25:0]);
    at_limit_d = (step_n_d == MAX_STEPS_W);
  end

  // The advance pulse must land in the EVAL cycle itself so that it never
  // overlaps the next ISSUE. For that reason it is decoded from the state
  // rather than registered.
  assign march_advance = (state_q == EVAL) && !is_hit_d && !is_far_d && !at_limit_d;

  // Sequencing FSM with registered handshake and payload outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      steps_q     <= '0;
      px_q        <= '0;
      py_q        <= '0;
      job_ready_q <= 1'b0;
      sdf_issue_q <= 1'b0;
      res_valid_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (job_valid && job_ready_q) begin
            px_q        <= job_px;
            py_q        <= job_py;
            steps_q     <= '0;
            hit_q       <= 1'b0;
            job_ready_q <= 1'b0;
            sdf_issue_q <= 1'b1;
            state_q     <= ISSUE;
          end else begin
            job_ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          sdf_issue_q <= 1'b0;
          cnt_q       <= LAT_LOAD;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (cnt_q == 6'd0) begin
            state_q <= EVAL;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        EVAL: begin
          steps_q <= step_n_d;
          if (is_hit_d) begin
            hit_q       <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (is_far_d || at_limit_d) begin
            hit_q       <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            sdf_issue_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign job_ready = job_ready_q;
  assign sdf_issue = sdf_issue_q;
  assign sdf_px    = px_q;
  assign sdf_py    = py_q;
  assign res_valid = res_valid_q;
  assign res_px    = px_q;
  assign res_py    = py_q;
  assign res_hit   = hit_q;
  assign res_steps = steps_q;

endmodule

// File: tb/tb_march_scheduler.sv
// Bench for march_scheduler: a directed job sequence, a fixed-latency sdf
// model and a result scoreboard.
module tb_march_scheduler;

  localparam int LAT = 12;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [9:0]  job_px = '0;
  logic [9:0]  job_py = '0;
  logic        sdf_issue;
  logic [9:0]  sdf_px, sdf_py;
  logic [26:0] sdf_distance;
  logic        march_advance;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [9:0]  res_px, res_py;
  logic        res_hit;
  logic [7:0]  res_steps;

  march_scheduler #(.SDF_LAT(LAT), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_px(job_px), .job_py(job_py),
    .sdf_issue(sdf_issue), .sdf_px(sdf_px), .sdf_py(sdf_py),
    .sdf_distance(sdf_distance), .march_advance(march_advance),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_px(res_px), .res_py(res_py), .res_hit(res_hit), .res_steps(res_steps)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [26:0] fp(input logic s, input int e, input logic [17:0] m);
    logic [7:0] ex;
    ex = e[7:0];
    return {s, ex, m};
  endfunction

  // 27-bit float constants: sign | 8-bit exponent (bias 127) | 18-bit mantissa
  logic [26:0] F_0625, F_EPS, F_ONE, F_1024, F_2048, F_NEG3, F_NEG2048, F_GARB;
  initial begin
    F_0625    = fp(1'b0, 123, 18'h0);
    F_EPS     = fp(1'b0, 124, 18'h0);
    F_ONE     = fp(1'b0, 127, 18'h0);
    F_1024    = fp(1'b0, 137, 18'h0);
    F_2048    = fp(1'b0, 138, 18'h0);
    F_NEG3    = fp(1'b1, 128, 18'h20000);
    F_NEG2048 = fp(1'b1, 138, 18'h0);
    F_GARB    = fp(1'b1, 0, 18'h0);
  end

  // sdf pipeline model: the value is valid exactly LAT cycles after an issue;
  // outside that cycle it drives a negative value that would read as a hit.
  logic [26:0] dist_tab [4];
  logic [LAT-1:0] sr;
  int eval_idx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sr       <= '0;
      eval_idx <= 0;
    end else begin
      sr <= {sr[LAT-2:0], sdf_issue};
      if (job_valid && job_ready) eval_idx <= 0;
      else if (sr[LAT-1]) eval_idx <= eval_idx + 1;
    end
  end

  always_comb begin
    sdf_distance = F_GARB;
    if (sr[LAT-1]) sdf_distance = (eval_idx < 4) ? dist_tab[eval_idx] : F_2048;
  end

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       hit;
    logic [7:0] steps;
    int         iss;
    int         adv;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_iss = 0, n_adv = 0, n_res = 0;
  int t_acc = 0, t_iss = 0, t_res = 0;
  logic rv_prev = 1'b0;

  // Monitor: counts pulses, timestamps events and scores consumed results.
  always @(negedge clk) begin
    if (reset) begin
      n_iss = 0;
      n_adv = 0;
      rv_prev = 1'b0;
    end else begin
      chk("issue_adv_exclusive", sdf_issue && march_advance, 0);
      if (sdf_issue) begin n_iss++; t_iss = cyc; end
      if (march_advance) n_adv++;
      if (job_valid && job_ready) t_acc = cyc;
      if (res_valid && !rv_prev) t_res = cyc;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res_px", res_px, e.px);
          chk("res_py", res_py, e.py);
          chk("res_hit", res_hit, e.hit);
          chk("res_steps", res_steps, e.steps);
          chk("n_issue", n_iss, e.iss);
          chk("n_advance", n_adv, e.adv);
        end
        n_iss = 0;
        n_adv = 0;
        n_res++;
      end
      rv_prev = res_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [9:0] px, input logic [9:0] py,
                         input logic [26:0] d0, input logic [26:0] d1,
                         input logic [26:0] d2, input logic [26:0] d3,
                         input logic hit, input int steps, input int iss,
                         input int adv, input int bp);
    exp_t e;
    int n;
    int r0;
    r0 = n_res;
    dist_tab[0] = d0; dist_tab[1] = d1; dist_tab[2] = d2; dist_tab[3] = d3;
    e.px = px; e.py = py; e.hit = hit; e.steps = 8'(steps); e.iss = iss; e.adv = adv;
    exp_q.push_back(e);
    res_ready = (bp == 0);
    job_px = px; job_py = py; job_valid = 1'b1;
    n = 0;
    while (!job_ready && n < 50) begin step(); n++; end
    chk("accept_timeout", n < 50, 1);
    step();
    job_valid = 1'b0;
    if (bp > 0) begin
      n = 0;
      while (!res_valid && n < 2000) begin step(); n++; end
      chk("res_valid_timeout", res_valid, 1);
      for (int i = 0; i < bp; i++) begin
        step();
        chk("bp_valid", res_valid, 1);
        chk("bp_payload", {res_px, res_py, res_hit, res_steps}, {px, py, hit, 8'(steps)});
        chk("bp_job_ready", job_ready, 0);
      end
      res_ready = 1'b1;
      chk("consume_job_ready", job_ready, 0);
      step();
      chk("post_consume_job_ready", job_ready, 1);
      chk("post_consume_valid", res_valid, 0);
    end
    n = 0;
    while (n_res == r0 && n < 2000) begin step(); n++; end
    chk("result_timeout", n_res != r0, 1);
    chk("latency", t_res - t_acc, (LAT + 1) * steps + 1);
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 4; i++) dist_tab[i] = '0;
    repeat (3) step();
    chk("rst_job_ready", job_ready, 0);
    chk("rst_pulses", {sdf_issue, march_advance, res_valid, res_hit}, 0);
    chk("rst_coords", {sdf_px, sdf_py, res_px, res_py, res_steps}, 0);
    reset = 1'b0;
    chk("rel_job_ready_low", job_ready, 0);
    step();
    chk("rel_job_ready_high", job_ready, 1);

    // first-step hit, exact issue and result timing
    run_job(10'd5, 10'd7, F_0625, F_ONE, F_ONE, F_ONE, 1'b1, 1, 1, 0, 0);
    chk("issue_latency", t_iss - t_acc, 1);
    // step-limit miss
    run_job(10'd12, 10'd34, F_ONE, F_ONE, F_ONE, F_ONE, 1'b0, 4, 4, 3, 0);
    // escape on step 2
    run_job(10'd100, 10'd200, F_ONE, F_2048, F_ONE, F_ONE, 1'b0, 2, 2, 1, 0);
    // negative distance wins over step limit
    run_job(10'd1023, 10'd0, F_ONE, F_ONE, F_ONE, F_NEG3, 1'b1, 4, 4, 3, 0);
    // exactly HIT_EPS is not a hit; exactly FAR_LIMIT escapes
    run_job(10'd300, 10'd301, F_EPS, F_1024, F_ONE, F_ONE, 1'b0, 2, 2, 1, 0);
    // large negative magnitude: hit wins over far
    run_job(10'd8, 10'd9, F_NEG2048, F_ONE, F_ONE, F_ONE, 1'b1, 1, 1, 0, 0);
    // backpressure for 20 cycles
    run_job(10'd33, 10'd44, F_ONE, F_0625, F_ONE, F_ONE, 1'b1, 2, 2, 1, 20);

    // reset in the middle of WAIT abandons the job
    r0 = n_res;
    dist_tab[0] = F_ONE; dist_tab[1] = F_ONE; dist_tab[2] = F_ONE; dist_tab[3] = F_ONE;
    job_px = 10'd9; job_py = 10'd3; job_valid = 1'b1;
    while (!job_ready) step();
    step();
    job_valid = 1'b0;
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_job_ready", job_ready, 0);
    chk("mid_rst_pulses", {sdf_issue, march_advance, res_valid, res_hit}, 0);
    chk("mid_rst_coords", {sdf_px, sdf_py, res_px, res_py, res_steps}, 0);
    repeat (2) step();
    reset = 1'b0;
    chk("mid_rel_job_ready_low", job_ready, 0);
    step();
    chk("mid_rel_job_ready_high", job_ready, 1);
    repeat (30) step();
    chk("no_result_after_abort", n_res, r0);
    run_job(10'd2, 10'd3, F_0625, F_ONE, F_ONE, F_ONE, 1'b1, 1, 1, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
